// File: rtl/vga_sram_pkg.sv
// Shared types and defaults for the VGA / cellular-automaton SRAM arbiter.
package vga_sram_pkg;

  localparam int ADDR_W_DEF = 18;
  localparam int DATA_W_DEF = 16;

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_TURN} state_t;
  typedef enum logic [1:0] {TAG_NONE, TAG_VGA, TAG_CA} tag_t;
  typedef enum logic {RR_READ, RR_WRITE} rr_t;
  typedef enum logic [1:0] {WIN_NONE, WIN_RD, WIN_WR} win_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker between CA read and CA write; the history bit lives in the parent.
module rr_arb2
  import vga_sram_pkg::*;
(
  input  logic rd,
  input  logic wr,
  input  rr_t  rr_last,
  output win_t winner
);

  always_comb begin
    winner = WIN_NONE;
    if (rd && wr) begin
      winner = (rr_last == RR_WRITE) ? WIN_RD : WIN_WR;
    end else if (rd) begin
      winner = WIN_RD;
    end else if (wr) begin
      winner = WIN_WR;
    end
  end

endmodule

// File: rtl/vga_sram_arbiter.sv
// Shares one async SRAM between VGA pixel fetch (absolute priority) and CA read/write (round-robin).
// Optional stall counters are built when ARB_STALL_STATS_EN is defined.
module vga_sram_arbiter
  import vga_sram_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              iCLK,
  input  logic              iRST_N,
  input  logic              iVGA_Req,
  input  logic [19:0]       iVGA_Addr,
  output logic [DATA_W-1:0] oVGA_Data,
  input  logic              iRD_Valid,
  output logic              oRD_Ready,
  input  logic [ADDR_W-1:0] iRD_Addr,
  output logic [DATA_W-1:0] oRD_Data,
  output logic              oRD_DValid,
  input  logic              iWR_Valid,
  output logic              oWR_Ready,
  input  logic [ADDR_W-1:0] iWR_Addr,
  input  logic [DATA_W-1:0] iWR_Data,
  output logic [ADDR_W-1:0] oSRAM_ADDR,
  output logic [DATA_W-1:0] oSRAM_DQ,
  output logic              oSRAM_DQ_OE,
  input  logic [DATA_W-1:0] iSRAM_DQ,
  output logic              oSRAM_WE_N,
  output logic              oSRAM_OE_N,
  output logic              oSRAM_CE_N
`ifdef ARB_STALL_STATS_EN
  ,
  input  logic              iStat_Clr,
  output logic [15:0]       oWR_Stall_Cnt,
  output logic [15:0]       oRD_Stall_Cnt
`endif
);

  state_t            state_q, state_d;
  rr_t               rr_last_q, rr_last_d;
  logic [ADDR_W-1:0] sram_addr_q, sram_addr_d;
  logic [DATA_W-1:0] sram_dq_q, sram_dq_d;
  logic              we_n_q, we_n_d, oe_n_q, oe_n_d, ce_n_q, ce_n_d, dq_oe_q, dq_oe_d;
  tag_t              tag0_q, tag0_d, tag1_q, tag1_d;
  logic [DATA_W-1:0] vga_data_q, vga_data_d, rd_data_q, rd_data_d;
  logic              rd_ready, wr_ready;
  win_t              winner;
  logic              unused_vga_hi;

  assign unused_vga_hi = ^iVGA_Addr[19:ADDR_W];

  rr_arb2 u_rr_arb2 (
    .rd      (iRD_Valid),
    .wr      (iWR_Valid),
    .rr_last (rr_last_q),
    .winner  (winner)
  );

  // A write that wins while a read is on the pins first spends one cycle in S_TURN.
  always_comb begin
    state_d     = S_IDLE;
    rr_last_d   = rr_last_q;
    sram_addr_d = sram_addr_q;
    sram_dq_d   = sram_dq_q;
    tag0_d      = TAG_NONE;
    rd_ready    = 1'b0;
    wr_ready    = 1'b0;
    if (iVGA_Req) begin
      state_d     = S_READ;
      sram_addr_d = iVGA_Addr[ADDR_W-1:0];
      tag0_d      = TAG_VGA;
    end else begin
      case (winner)
        WIN_RD: begin
          state_d     = S_READ;
          sram_addr_d = iRD_Addr;
          tag0_d      = TAG_CA;
          rd_ready    = 1'b1;
          rr_last_d   = RR_READ;
        end
        WIN_WR: begin
          if (state_q != S_READ) begin
            state_d     = S_WRITE;
            sram_addr_d = iWR_Addr;
            sram_dq_d   = iWR_Data;
            wr_ready    = 1'b1;
            rr_last_d   = RR_WRITE;
          end else begin
            state_d = S_TURN;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    oe_n_d  = (state_d != S_READ);
    we_n_d  = (state_d != S_WRITE);
    ce_n_d  = !((state_d == S_READ) || (state_d == S_WRITE));
    dq_oe_d = (state_d == S_WRITE);

    // tag0 describes the cycle on the pins, so it selects where the sampled DQ goes.
    tag1_d     = tag0_q;
    vga_data_d = (tag0_q == TAG_VGA) ? iSRAM_DQ : vga_data_q;
    rd_data_d  = (tag0_q == TAG_CA) ? iSRAM_DQ : rd_data_q;
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q     <= S_IDLE;
      rr_last_q   <= RR_WRITE;
      sram_addr_q <= '0;
      sram_dq_q   <= '0;
      we_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
      ce_n_q      <= 1'b1;
      dq_oe_q     <= 1'b0;
      tag0_q      <= TAG_NONE;
      tag1_q      <= TAG_NONE;
      vga_data_q  <= '0;
      rd_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      rr_last_q   <= rr_last_d;
      sram_addr_q <= sram_addr_d;
      sram_dq_q   <= sram_dq_d;
      we_n_q      <= we_n_d;
      oe_n_q      <= oe_n_d;
      ce_n_q      <= ce_n_d;
      dq_oe_q     <= dq_oe_d;
      tag0_q      <= tag0_d;
      tag1_q      <= tag1_d;
      vga_data_q  <= vga_data_d;
      rd_data_q   <= rd_data_d;
    end
  end

  assign oRD_Ready   = rd_ready;
  assign oWR_Ready   = wr_ready;
  assign oVGA_Data   = vga_data_q;
  assign oRD_Data    = rd_data_q;
  assign oRD_DValid  = (tag1_q == TAG_CA);
  assign oSRAM_ADDR  = sram_addr_q;
  assign oSRAM_DQ    = sram_dq_q;
  assign oSRAM_DQ_OE = dq_oe_q;
  assign oSRAM_WE_N  = we_n_q;
  assign oSRAM_OE_N  = oe_n_q;
  assign oSRAM_CE_N  = ce_n_q;

`ifdef ARB_STALL_STATS_EN
  logic [15:0] wr_stall_q, wr_stall_d, rd_stall_q, rd_stall_d;

  // Saturating counts of cycles a CA port waits; clear wins over counting.
  always_comb begin
    wr_stall_d = wr_stall_q;
    rd_stall_d = rd_stall_q;
    if (iStat_Clr) begin
      wr_stall_d = '0;
      rd_stall_d = '0;
    end else begin
      if (iWR_Valid && !wr_ready && (wr_stall_q != 16'hFFFF)) wr_stall_d = wr_stall_q + 16'd1;
      if (iRD_Valid && !rd_ready && (rd_stall_q != 16'hFFFF)) rd_stall_d = rd_stall_q + 16'd1;
    end
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      wr_stall_q <= '0;
      rd_stall_q <= '0;
    end else begin
      wr_stall_q <= wr_stall_d;
      rd_stall_q <= rd_stall_d;
    end
  end

  assign oWR_Stall_Cnt = wr_stall_q;
  assign oRD_Stall_Cnt = rd_stall_q;
`endif

endmodule

// File: tb/tb_vga_sram_arbiter.sv
// Self-checking bench for vga_sram_arbiter with an async SRAM model and a read-data scoreboard.
module tb_vga_sram_arbiter;

  localparam int AW = 18;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          iVGA_Req;
  logic [19:0]   iVGA_Addr;
  logic [DW-1:0] oVGA_Data;
  logic          iRD_Valid, oRD_Ready, oRD_DValid;
  logic [AW-1:0] iRD_Addr;
  logic [DW-1:0] oRD_Data;
  logic          iWR_Valid, oWR_Ready;
  logic [AW-1:0] iWR_Addr;
  logic [DW-1:0] iWR_Data;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_dq, sram_dq_in;
  logic          dq_oe, we_n, oe_n, ce_n;
`ifdef ARB_STALL_STATS_EN
  logic          iStat_Clr;
  logic [15:0]   oWR_Stall_Cnt, oRD_Stall_Cnt;
`endif

  logic [DW-1:0] mem     [0:1023];
  logic [DW-1:0] ref_mem [0:1023];

  typedef struct {
    logic [DW-1:0] data;
    int            due;
  } exp_t;

  exp_t vga_q[$];
  exp_t rd_q[$];
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  bit   mon_en = 1'b0;

  always #20 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  vga_sram_arbiter dut (
    .iCLK        (clk),
    .iRST_N      (rst_n),
    .iVGA_Req    (iVGA_Req),
    .iVGA_Addr   (iVGA_Addr),
    .oVGA_Data   (oVGA_Data),
    .iRD_Valid   (iRD_Valid),
    .oRD_Ready   (oRD_Ready),
    .iRD_Addr    (iRD_Addr),
    .oRD_Data    (oRD_Data),
    .oRD_DValid  (oRD_DValid),
    .iWR_Valid   (iWR_Valid),
    .oWR_Ready   (oWR_Ready),
    .iWR_Addr    (iWR_Addr),
    .iWR_Data    (iWR_Data),
    .oSRAM_ADDR  (sram_addr),
    .oSRAM_DQ    (sram_dq),
    .oSRAM_DQ_OE (dq_oe),
    .iSRAM_DQ    (sram_dq_in),
    .oSRAM_WE_N  (we_n),
    .oSRAM_OE_N  (oe_n),
    .oSRAM_CE_N  (ce_n)
`ifdef ARB_STALL_STATS_EN
    ,
    .iStat_Clr     (iStat_Clr),
    .oWR_Stall_Cnt (oWR_Stall_Cnt),
    .oRD_Stall_Cnt (oRD_Stall_Cnt)
`endif
  );

  // Async SRAM: combinational read while selected, write lands at the edge ending a write cycle.
  assign sram_dq_in = (!oe_n && !ce_n) ? mem[sram_addr[9:0]] : 16'h0000;

  always @(posedge clk) begin
    if (!we_n && !ce_n && dq_oe) mem[sram_addr[9:0]] <= sram_dq;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // 1 = read on pins, 2 = write on pins, 0 = bus released, 3 = illegal strobe mix.
  function automatic int pinState();
    if (!oe_n && !ce_n && we_n && !dq_oe) return 1;
    if (!we_n && !ce_n && oe_n && dq_oe) return 2;
    if (we_n && oe_n && ce_n && !dq_oe) return 0;
    return 3;
  endfunction

  // Scoreboard: expected read data queued at grant, compared two edges later.
  always @(negedge clk) begin
    exp_t e;
    if (mon_en && rst_n) begin
      if (iVGA_Req) begin
        checkOutput("vga_blocks_wr_ready", {31'b0, oWR_Ready}, 0);
        checkOutput("vga_blocks_rd_ready", {31'b0, oRD_Ready}, 0);
        vga_q.push_back('{ref_mem[iVGA_Addr[9:0]], cyc + 2});
      end
      if (iWR_Valid && oWR_Ready) ref_mem[iWR_Addr[9:0]] = iWR_Data;
      if (iRD_Valid && oRD_Ready) rd_q.push_back('{ref_mem[iRD_Addr[9:0]], cyc + 2});
      if (vga_q.size() > 0 && vga_q[0].due <= cyc) begin
        e = vga_q.pop_front();
        checkOutput("vga_data", {16'b0, oVGA_Data}, {16'b0, e.data});
      end
      if (oRD_DValid) begin
        if (rd_q.size() == 0) begin
          checkOutput("rd_dvalid_unexpected", {31'b0, oRD_DValid}, 0);
        end else begin
          e = rd_q.pop_front();
          checkOutput("rd_data", {16'b0, oRD_Data}, {16'b0, e.data});
          checkOutput("rd_latency", cyc, e.due);
        end
      end else if (rd_q.size() > 0 && rd_q[0].due <= cyc) begin
        e = rd_q.pop_front();
        checkOutput("rd_dvalid_missing", {31'b0, oRD_DValid}, 1);
      end
    end
  end

  task automatic applyReset();
    @(posedge clk);
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic applyStimulus(input logic vga, input logic [19:0] vaddr,
                               input logic rd, input logic [AW-1:0] raddr,
                               input logic wr, input logic [AW-1:0] waddr,
                               input logic [DW-1:0] wdata);
    @(posedge clk);
    #1;
    iVGA_Req  = vga;
    iVGA_Addr = vaddr;
    iRD_Valid = rd;
    iRD_Addr  = raddr;
    iWR_Valid = wr;
    iWR_Addr  = waddr;
    iWR_Data  = wdata;
  endtask

  initial begin
    int exp_seq[6] = '{1, 0, 2, 1, 0, 2};
    bit got;

    rst_n     = 1'b0;
    iVGA_Req  = 1'b0;
    iVGA_Addr = '0;
    iRD_Valid = 1'b0;
    iRD_Addr  = '0;
    iWR_Valid = 1'b0;
    iWR_Addr  = '0;
    iWR_Data  = '0;
`ifdef ARB_STALL_STATS_EN
    iStat_Clr = 1'b0;
`endif
    for (int i = 0; i < 1024; i++) begin
      mem[i]     = 16'(i) ^ 16'h5A00;
      ref_mem[i] = 16'(i) ^ 16'h5A00;
    end
    mem[16'h010] = 16'hABCD; ref_mem[16'h010] = 16'hABCD;
    mem[16'h011] = 16'h1111; ref_mem[16'h011] = 16'h1111;
    mem[16'h012] = 16'h1212; ref_mem[16'h012] = 16'h1212;
    mem[16'h020] = 16'h2222; ref_mem[16'h020] = 16'h2222;
    mem[16'h200] = 16'h0BAD; ref_mem[16'h200] = 16'h0BAD;

    // Reset release with no requests
    applyReset();
    @(negedge clk);
    checkOutput("rst_pins_idle", pinState(), 0);
    checkOutput("rst_we_n", {31'b0, we_n}, 1);
    checkOutput("rst_rd_ready", {31'b0, oRD_Ready}, 0);
    checkOutput("rst_wr_ready", {31'b0, oWR_Ready}, 0);
    checkOutput("rst_rd_dvalid", {31'b0, oRD_DValid}, 0);
    checkOutput("rst_vga_data", {16'b0, oVGA_Data}, 0);
    mon_en = 1'b1;

    // VGA fetch with a CA write held pending; upper address bits must be dropped
    applyStimulus(1'b1, 20'hC0010, 1'b0, '0, 1'b1, 18'h040, 16'h4444);
    applyStimulus(1'b1, 20'h00011, 1'b0, '0, 1'b1, 18'h040, 16'h4444);
    @(negedge clk);
    checkOutput("vga_pin_addr", {14'b0, sram_addr}, 32'h00010);
    checkOutput("vga_pin_read", pinState(), 1);
    applyStimulus(1'b1, 20'h00012, 1'b0, '0, 1'b1, 18'h040, 16'h4444);
    applyStimulus(1'b0, 20'h0, 1'b0, '0, 1'b0, '0, '0);
    repeat (5) @(negedge clk);
    checkOutput("vga_data_hold", {16'b0, oVGA_Data}, 32'h1212);
    checkOutput("vga_q_drained", vga_q.size(), 0);

    // Contending CA read and write alternate with a turnaround before each write
    applyReset();
    applyStimulus(1'b0, 20'h0, 1'b1, 18'h020, 1'b1, 18'h030, 16'h5555);
    @(negedge clk);
    checkOutput("rr_first_rd_ready", {31'b0, oRD_Ready}, 1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checkOutput($sformatf("rr_seq_%0d", i), pinState(), exp_seq[i]);
    end
    applyStimulus(1'b0, 20'h0, 1'b0, '0, 1'b0, '0, '0);
    repeat (4) @(negedge clk);
    checkOutput("rr_rd_q_drained", rd_q.size(), 0);
    checkOutput("rr_write_landed", {16'b0, mem[16'h030]}, 32'h5555);

    // CA write then immediate read of the same word; no turnaround for write->read
    applyStimulus(1'b0, 20'h0, 1'b0, '0, 1'b1, 18'h100, 16'h1234);
    got = 1'b0;
    for (int n = 0; n < 8 && !got; n++) begin
      @(negedge clk);
      got = oWR_Ready;
    end
    checkOutput("wr_grant", {31'b0, got}, 1);
    applyStimulus(1'b0, 20'h0, 1'b1, 18'h100, 1'b0, '0, '0);
    @(negedge clk);
    checkOutput("wr_on_pins", pinState(), 2);
    checkOutput("rd_after_wr_ready", {31'b0, oRD_Ready}, 1);
    applyStimulus(1'b0, 20'h0, 1'b0, '0, 1'b0, '0, '0);
    @(negedge clk);
    checkOutput("rd_no_turn", pinState(), 1);
    repeat (3) @(negedge clk);
    checkOutput("raw_rd_q_drained", rd_q.size(), 0);
    checkOutput("raw_mem", {16'b0, mem[16'h100]}, 32'h1234);

    // Reset in the middle of a write cycle
    applyStimulus(1'b0, 20'h0, 1'b0, '0, 1'b1, 18'h200, 16'hDEAD);
    @(negedge clk);
    checkOutput("abort_wr_grant", {31'b0, oWR_Ready}, 1);
    applyStimulus(1'b0, 20'h0, 1'b0, '0, 1'b0, '0, '0);
    #5 rst_n = 1'b0;
    #1;
    checkOutput("abort_we_n", {31'b0, we_n}, 1);
    checkOutput("abort_dq_oe", {31'b0, dq_oe}, 0);
    checkOutput("abort_ce_n", {31'b0, ce_n}, 1);
    @(posedge clk);
    #1;
    checkOutput("abort_no_write", {16'b0, mem[16'h200]}, 32'h0BAD);
    ref_mem[16'h200] = 16'h0BAD;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

`ifdef ARB_STALL_STATS_EN
    // Continuous VGA starves the CA write until its stall counter saturates
    applyStimulus(1'b1, 20'h0, 1'b0, '0, 1'b1, 18'h040, 16'h4444);
    repeat (70000) @(posedge clk);
    @(negedge clk);
    checkOutput("wr_stall_sat", {16'b0, oWR_Stall_Cnt}, 32'hFFFF);
    checkOutput("rd_stall_idle", {16'b0, oRD_Stall_Cnt}, 0);
    applyStimulus(1'b0, 20'h0, 1'b0, '0, 1'b0, '0, '0);
    iStat_Clr = 1'b1;
    @(posedge clk);
    #1 iStat_Clr = 1'b0;
    @(negedge clk);
    checkOutput("wr_stall_clr", {16'b0, oWR_Stall_Cnt}, 0);
    repeat (3) @(negedge clk);
`endif

    checkOutput("final_vga_q_empty", vga_q.size(), 0);
    checkOutput("final_rd_q_empty", rd_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vga_sram_arbiter.md
Name: vga_sram_arbiter

Overview:
- Shares one asynchronous single-port SRAM frame buffer between three requesters: VGA pixel fetch, cellular-automaton (CA) row read, and CA row write.
- VGA fetch is never delayed. It issues one read per pixel clock during active video; its address is issued two pixels ahead of display.
- CA accesses fill the remaining slots (blanking, idle cycles) under round-robin.
- Sits between the VGA timing controller, the CA update engine and the SRAM pins.

Parameters:
- ADDR_W, 18, SRAM word address width (VGA address input is truncated to this).
- DATA_W, 16, SRAM data width.

Ports:
- iCLK  in  1  pixel clock (25.175 MHz); all logic on rising edge.
- iRST_N  in  1  asynchronous active-low reset.
- iVGA_Req  in  1  VGA read request this cycle (active-video lookahead).
- iVGA_Addr  in  20  VGA pixel address; low ADDR_W bits used.
- oVGA_Data  out  DATA_W  VGA read data, registered.
- iRD_Valid  in  1  CA read request.
- oRD_Ready  out  1  CA read accepted this cycle.
- iRD_Addr  in  ADDR_W  CA read address.
- oRD_Data  out  DATA_W  CA read data.
- oRD_DValid  out  1  one-cycle pulse marking oRD_Data valid.
- iWR_Valid  in  1  CA write request.
- oWR_Ready  out  1  CA write accepted this cycle.
- iWR_Addr  in  ADDR_W  CA write address.
- iWR_Data  in  DATA_W  CA write data.
- oSRAM_ADDR  out  ADDR_W  registered SRAM address.
- oSRAM_DQ  out  DATA_W  registered write data.
- oSRAM_DQ_OE  out  1  drive DQ pins.
- iSRAM_DQ  in  DATA_W  SRAM read data.
- oSRAM_WE_N, oSRAM_OE_N, oSRAM_CE_N  out  1 each  SRAM strobes, registered.

Behaviour:
- Reset (async, iRST_N low):
  - state=S_IDLE; rr_last=WRITE; all data outputs 0.
  - oSRAM_WE_N=1, oSRAM_OE_N=1, oSRAM_CE_N=1, oSRAM_DQ_OE=0.
  - oRD_DValid=0, read pipeline flags cleared.
  - Reset mid-access aborts the access. A write accepted in the same cycle reset asserts is dropped.
- FSM: state holds the SRAM cycle currently on the pins.
  - S_IDLE: bus released.
  - S_READ: OE_N=0, CE_N=0.
  - S_WRITE: WE_N=0, CE_N=0, DQ_OE=1.
  - S_TURN: bus released, inserted only between a read and a write.
- Per-cycle decision, from current state and inputs; the next state is registered:
  - iVGA_Req=1 -> S_READ with VGA address. oRD_Ready=0, oWR_Ready=0.
  - Otherwise CA candidates are rd=iRD_Valid and wr=iWR_Valid. If both are set, pick the one opposite rr_last.
  - rd wins -> S_READ. oRD_Ready=1. rr_last<=READ.
  - wr wins and state!=S_READ -> S_WRITE. oWR_Ready=1. rr_last<=WRITE.
  - wr wins and state==S_READ -> S_TURN. oWR_Ready=0; rr_last unchanged. The write is accepted next cycle if still winning.
  - Nothing pending -> S_IDLE.
- Write -> read needs no turnaround: DQ_OE drops on the same edge OE_N falls.
- Handshakes:
  - oRD_Ready and oWR_Ready are combinational.
  - A transfer occurs when Valid & Ready. Requesters hold address and data until the transfer.
  - Valid may drop without a transfer.
- Read latency:
  - Request granted at edge k; pins driven from edge k+1; iSRAM_DQ captured at edge k+2.
  - VGA: oVGA_Data is updated at edge k+2 and holds its value otherwise.
  - CA: oRD_Data is updated at edge k+2 with oRD_DValid=1 for exactly that cycle.
  - A 2-deep source-tag shift register routes the captured data to the VGA or CA output.
- Boundaries:
  - Continuous iVGA_Req starves CA indefinitely; this is by design, since CA runs in blanking.
  - Back-to-back CA reads and writes alternate, with S_TURN inserted on each read->write change.
  - rr_last changes only on an accepted CA transfer.

Optional Feature:
- Macro ARB_STALL_STATS_EN.
- When defined, adds outputs oWR_Stall_Cnt[15:0] and oRD_Stall_Cnt[15:0].
  - Each counts cycles with Valid=1 & Ready=0 for its port.
  - Counters saturate at 16'hFFFF and clear on reset or on a new input iStat_Clr.
- When undefined, the ports, counters and iStat_Clr are absent; all other behaviour is identical.

Decomposition:
- Shared package vga_sram_pkg:
  - state enum (S_IDLE, S_READ, S_WRITE, S_TURN).
  - source-tag enum (TAG_NONE, TAG_VGA, TAG_CA).
  - ADDR_W and DATA_W defaults.
- One sub-module: rr_arb2, the two-way round-robin picker. Inputs are rd, wr and rr_last; output is the winner. It is purely combinational, and rr_last is held in the parent.

Test Plan:
1. Reset release, no requests -> state S_IDLE; all strobes 1; DQ_OE=0; both Ready=0.
2. iVGA_Req=1 at addr 0x00010 with SRAM model returning 0xABCD; iWR_Valid held -> oWR_Ready=0 throughout; oVGA_Data=0xABCD two edges after grant.
3. iVGA_Req=0; iRD_Valid and iWR_Valid both held, rr_last=WRITE -> grants in order READ, TURN, WRITE, READ, TURN, WRITE; one oRD_DValid pulse per read.
4. CA write 0x1234 to 0x00100, then CA read of 0x00100 -> oRD_Data=0x1234 with oRD_DValid at exactly edge grant+2; no TURN between the write and the read.
5. Assert iRST_N=0 during S_WRITE -> WE_N=1 and DQ_OE=0 immediately (async); memory model shows no partial write after the clock.
6. With ARB_STALL_STATS_EN: hold iWR_Valid under continuous VGA for 70000 cycles -> oWR_Stall_Cnt=16'hFFFF (saturated); assert iStat_Clr -> 0.
